// File: rtl/conv_img_src.sv
// Frame source for the conv image pipeline: holds one image, one kernel and a bias,
// then streams weights, bias and pixels through a two-stage read/output pipeline.
module conv_img_src #(
    parameter int AW = 14,
    parameter int BW = 8,
    parameter int CH = 3,
    parameter int DW = 64,
    parameter int DH = 64,
    parameter int WW = 3,
    parameter int WH = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_pix_wr_en,
    input  logic [AW-1:0]               i_pix_wr_addr,
    input  logic [CH*BW-1:0]            i_pix_wr_data,
    input  logic                        i_wgt_wr_en,
    input  logic [$clog2(WW*WH)-1:0]    i_wgt_wr_addr,
    input  logic [BW-1:0]               i_wgt_wr_data,
    input  logic                        i_bias_wr_en,
    input  logic [BW-1:0]               i_bias_wr_data,
    input  logic                        i_start,
    input  logic                        i_hold,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_weight_valid,
    output logic                        o_weight_last,
    output logic [BW-1:0]               o_weight,
    output logic                        o_bias_valid,
    output logic [BW-1:0]               o_bias,
    output logic                        o_data_valid,
    output logic                        o_data_last,
    output logic [CH*BW-1:0]            o_data
);

    localparam int NPIX = DW * DH;
    localparam int NW   = WW * WH;
    localparam int WAW  = $clog2(NW);
    localparam int PAW  = $clog2(NPIX);
    localparam int PW   = CH * BW;
    localparam logic [WAW-1:0] W_LAST = WAW'(NW - 1);
    localparam logic [AW-1:0]  P_LAST = AW'(NPIX - 1);
    localparam logic [AW:0]    P_LIM  = (AW + 1)'(NPIX);

    typedef enum logic [2:0] {S_IDLE, S_WGT, S_BIAS, S_DATA, S_FIN} state_t;

    state_t          state_q, state_d;
    logic [WAW-1:0]  wcnt_q, wcnt_d;
    logic [AW-1:0]   pcnt_q, pcnt_d;
    logic [BW-1:0]   wgt_q [NW];
    logic [BW-1:0]   wgt_d [NW];
    logic [BW-1:0]   bias_q, bias_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    // beat flags: {weight_valid, weight_last, bias_valid, data_valid, data_last}
    logic [4:0]      iss;
    logic [4:0]      s1_flags_q, s1_flags_d;
    logic [4:0]      out_flags_q, out_flags_d;
    logic [BW-1:0]   s1_wgt_q, s1_wgt_d;
    logic [BW-1:0]   wgt_out_q, wgt_out_d;
    logic [PW-1:0]   data_out_q, data_out_d;
    logic [PW-1:0]   rd_data_q;
    logic [PW-1:0]   mem [NPIX];
    logic            wr_ok;
    logic            pix_wr_ok;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        pcnt_d    = pcnt_q;
        wgt_d     = wgt_q;
        bias_d    = bias_q;
        iss       = '0;
        wr_ok     = (state_q == S_IDLE) && !busy_q;
        pix_wr_ok = wr_ok && i_pix_wr_en && ({1'b0, i_pix_wr_addr} < P_LIM);

        if (wr_ok && i_wgt_wr_en && (i_wgt_wr_addr <= W_LAST)) begin
            wgt_d[i_wgt_wr_addr] = i_wgt_wr_data;
        end
        if (wr_ok && i_bias_wr_en) begin
            bias_d = i_bias_wr_data;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_WGT;
                    wcnt_d  = '0;
                    pcnt_d  = '0;
                end
            end
            S_WGT: begin
                if (!i_hold) begin
                    iss[4] = 1'b1;
                    if (wcnt_q == W_LAST) begin
                        iss[3]  = 1'b1;
                        wcnt_d  = '0;
                        state_d = S_BIAS;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            S_BIAS: begin
                if (!i_hold) begin
                    iss[2]  = 1'b1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (!i_hold) begin
                    iss[1] = 1'b1;
                    if (pcnt_q == P_LAST) begin
                        iss[0]  = 1'b1;
                        pcnt_d  = '0;
                        state_d = S_FIN;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
            end
            // Leave one cycle early so o_busy (one cycle behind the state) drops
            // together with o_done and a new start lands right after the last beat.
            S_FIN: begin
                if (s1_flags_q[0]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_q != S_IDLE);
        done_d      = out_flags_q[0];
        s1_flags_d  = iss;
        out_flags_d = s1_flags_q;
        s1_wgt_d    = wgt_q[wcnt_q];
        wgt_out_d   = s1_wgt_q;
        data_out_d  = rd_data_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            pcnt_q      <= '0;
            for (int unsigned i = 0; i < NW; i++) begin
                wgt_q[i] <= '0;
            end
            bias_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            s1_flags_q  <= '0;
            out_flags_q <= '0;
            s1_wgt_q    <= '0;
            wgt_out_q   <= '0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            pcnt_q      <= pcnt_d;
            wgt_q       <= wgt_d;
            bias_q      <= bias_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            s1_flags_q  <= s1_flags_d;
            out_flags_q <= out_flags_d;
            s1_wgt_q    <= s1_wgt_d;
            wgt_out_q   <= wgt_out_d;
            data_out_q  <= data_out_d;
        end
    end

    // Frame buffer contents survive reset; the read port runs every cycle.
    always_ff @(posedge i_clk) begin
        if (pix_wr_ok) begin
            mem[i_pix_wr_addr[PAW-1:0]] <= i_pix_wr_data;
        end
        rd_data_q <= mem[pcnt_q[PAW-1:0]];
    end

    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_weight_valid = out_flags_q[4];
    assign o_weight_last  = out_flags_q[3];
    assign o_weight       = wgt_out_q;
    assign o_bias_valid   = out_flags_q[2];
    assign o_bias         = bias_q;
    assign o_data_valid   = out_flags_q[1];
    assign o_data_last    = out_flags_q[0];
    assign o_data         = data_out_q;

endmodule

// File: tb/tb_conv_img_src.sv
// Bench for conv_img_src: a beat-index reference model predicts every output each
// cycle; per-frame records pin the model against hand-computed values.
module tb_conv_img_src;

    localparam int NW   = 9;
    localparam int NPIX = 4096;
    localparam int NB   = NW + 1 + NPIX;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic [13:0] pix_addr = '0;
    logic [23:0] pix_data = '0;
    logic        wgt_en = 1'b0;
    logic [3:0]  wgt_addr = '0;
    logic [7:0]  wgt_data = '0;
    logic        bias_en = 1'b0;
    logic [7:0]  bias_data = '0;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic        o_busy, o_done, o_weight_valid, o_weight_last, o_bias_valid;
    logic        o_data_valid, o_data_last;
    logic [7:0]  o_weight, o_bias;
    logic [23:0] o_data;

    conv_img_src #(.AW(14), .BW(8), .CH(3), .DW(64), .DH(64), .WW(3), .WH(3)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_pix_wr_en(pix_en), .i_pix_wr_addr(pix_addr), .i_pix_wr_data(pix_data),
        .i_wgt_wr_en(wgt_en), .i_wgt_wr_addr(wgt_addr), .i_wgt_wr_data(wgt_data),
        .i_bias_wr_en(bias_en), .i_bias_wr_data(bias_data),
        .i_start(start), .i_hold(hold),
        .o_busy(o_busy), .o_done(o_done),
        .o_weight_valid(o_weight_valid), .o_weight_last(o_weight_last), .o_weight(o_weight),
        .o_bias_valid(o_bias_valid), .o_bias(o_bias),
        .o_data_valid(o_data_valid), .o_data_last(o_data_last), .o_data(o_data)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    longint cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: stores, frame-in-progress flag, next beat index and a
    // two-deep delay line of issued beat indices (-1 = no beat).
    logic [23:0] pix_m [NPIX];
    logic [7:0]  w_m [NW];
    logic [7:0]  b_m = '0;
    int  p1 = -1, p2 = -1, mpos = 0, iss;
    bit  inf = 0, ebusy = 0, edone = 0, oi, ob;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            p1 = -1; p2 = -1; inf = 0; ebusy = 0; edone = 0; mpos = 0; b_m = '0;
            for (int i = 0; i < NW; i++) w_m[i] = '0;
        end else begin
            oi = inf;
            ob = ebusy;
            if (!oi && !ob) begin
                if (pix_en && pix_addr < 14'(NPIX)) pix_m[pix_addr[11:0]] = pix_data;
                if (wgt_en && wgt_addr < 4'(NW)) w_m[wgt_addr] = wgt_data;
                if (bias_en) b_m = bias_data;
            end
            iss = -1;
            if (oi && mpos < NB && !hold) begin
                iss = mpos;
                mpos++;
            end
            edone = (p2 == NB - 1);
            p2 = p1;
            p1 = iss;
            if (p2 == NB - 1) inf = 0;
            ebusy = oi;
            if (!oi && start) begin
                inf = 1;
                mpos = 0;
            end
        end
    end

    // Per-frame records for the literal checks.
    logic [7:0]  wq[$];
    logic [7:0]  bq[$];
    longint      wcyc[$], lastq[$], doneq[$];
    int          dcnt, nvalid;
    logic [23:0] dfirst, dlast;
    longint      first_vc, last_vc;

    task automatic clr();
        wq.delete(); bq.delete(); wcyc.delete(); lastq.delete(); doneq.delete();
        dcnt = 0; nvalid = 0; dfirst = '0; dlast = '0; first_vc = 0; last_vc = 0;
    endtask

    int e;
    logic [4:0] ef;
    initial forever begin
        @(posedge clk);
        #2;
        if (rst) begin
            chk("reset_outputs", {o_busy, o_done, o_weight_valid, o_weight_last, o_weight,
                o_bias_valid, o_bias, o_data_valid, o_data_last, o_data}, '0);
        end else begin
            e  = p2;
            ef = {e >= 0 && e < NW, e == NW - 1, e == NW, e > NW, e == NB - 1};
            chk("busy", o_busy, ebusy);
            chk("done", o_done, edone);
            chk("flags", {o_weight_valid, o_weight_last, o_bias_valid, o_data_valid, o_data_last}, ef);
            chk("bias", o_bias, b_m);
            if (ef[4]) chk("weight", o_weight, w_m[e]);
            if (ef[1]) chk("data", o_data, pix_m[e - NW - 1]);
            if (o_weight_valid) begin wq.push_back(o_weight); wcyc.push_back(cyc); end
            if (o_bias_valid) bq.push_back(o_bias);
            if (o_data_valid) begin
                if (dcnt == 0) dfirst = o_data;
                dlast = o_data;
                dcnt++;
            end
            if (o_data_last) lastq.push_back(cyc);
            if (o_done) doneq.push_back(cyc);
            if (o_weight_valid || o_bias_valid || o_data_valid) begin
                if (nvalid == 0) first_vc = cyc;
                last_vc = cyc;
                nvalid++;
            end
        end
    end

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (o_done) seen = 1;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: no o_done within %0d cycles", bound);
        end
    endtask

    task automatic frame_pins(input string tag, input logic [7:0] w0, input logic [7:0] b0,
                              input logic [23:0] d0, input longint span);
        chk({tag, "_wcount"}, wq.size(), 9);
        if (wq.size() == 9) begin
            chk({tag, "_w0"}, wq[0], w0);
        end
        chk({tag, "_bcount"}, bq.size(), 1);
        if (bq.size() == 1) chk({tag, "_b"}, bq[0], b0);
        chk({tag, "_dcount"}, dcnt, NPIX);
        chk({tag, "_dfirst"}, dfirst, d0);
        chk({tag, "_nvalid"}, nvalid, NB);
        chk({tag, "_span"}, last_vc - first_vc + 1, span);
        chk({tag, "_ndone"}, doneq.size(), 1);
        if (doneq.size() == 1) chk({tag, "_done_after_first"}, doneq[0] - first_vc, span);
    endtask

    logic [7:0] lb;
    initial begin
        clr();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Ramp image with simultaneous kernel/bias loading on the first beats.
        for (int a = 0; a < NPIX; a++) begin
            @(negedge clk);
            lb = a[7:0];
            pix_en = 1'b1; pix_addr = 14'(a); pix_data = {lb + 8'd2, lb + 8'd1, lb};
            wgt_en = (a < NW); wgt_addr = 4'(a); wgt_data = 8'(a + 1);
            bias_en = (a == 0); bias_data = 8'd5;
        end
        @(negedge clk);
        wgt_en = 1'b0; bias_en = 1'b0;
        pix_addr = 14'd4096; pix_data = 24'hABCDEF;
        wgt_en = 1'b1; wgt_addr = 4'd9; wgt_data = 8'hEE;
        @(negedge clk);
        pix_en = 1'b0; wgt_en = 1'b0;

        // Full frame, no stalls.
        clr();
        start_pulse();
        wait_done(6000);
        frame_pins("f1", 8'd1, 8'd5, 24'h020100, NB);
        if (wq.size() == 9) chk("f1_w8", wq[8], 8'd9);
        chk("f1_dlast", dlast, 24'h0100FF);
        chk("f1_nlast", lastq.size(), 1);
        if (lastq.size() == 1 && doneq.size() == 1) chk("f1_done_lat", doneq[0] - lastq[0], 1);
        repeat (3) @(negedge clk);

        // One stall on the bias beat, three mid-pixel stream.
        clr();
        start_pulse();
        repeat (9) @(negedge clk);
        hold = 1'b1;
        @(negedge clk); hold = 1'b0;
        repeat (2000) @(negedge clk);
        hold = 1'b1;
        repeat (3) @(negedge clk);
        hold = 1'b0;
        wait_done(6000);
        frame_pins("f2", 8'd1, 8'd5, 24'h020100, NB + 4);
        repeat (3) @(negedge clk);

        // Writes and start while busy must not affect this frame or the next.
        clr();
        start_pulse();
        repeat (2000) @(negedge clk);
        pix_en = 1'b1; pix_addr = '0; pix_data = 24'hFFFFFF;
        wgt_en = 1'b1; wgt_addr = '0; wgt_data = 8'h7F;
        bias_en = 1'b1; bias_data = 8'h11; start = 1'b1;
        @(negedge clk);
        pix_en = 1'b0; wgt_en = 1'b0; bias_en = 1'b0; start = 1'b0;
        wait_done(6000);
        frame_pins("f3", 8'd1, 8'd5, 24'h020100, NB);
        repeat (20) @(negedge clk);
        chk("f3_no_restart", o_busy, 1'b0);
        clr();
        start_pulse();
        wait_done(6000);
        frame_pins("f4", 8'd1, 8'd5, 24'h020100, NB);
        repeat (3) @(negedge clk);

        // Reset while pixel 1000 is on the output.
        clr();
        start_pulse();
        repeat (1012) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {o_busy, o_done, o_weight_valid, o_weight_last, o_bias_valid,
            o_data_valid, o_data_last, o_bias}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clr();
        start_pulse();
        wait_done(6000);
        frame_pins("f6", 8'd0, 8'd0, 24'h020100, NB);
        repeat (3) @(negedge clk);

        // Start held high: second frame begins straight after the first.
        clr();
        @(negedge clk); start = 1'b1;
        wait_done(6000);
        start = 1'b0;
        wait_done(6000);
        chk("b2b_nlast", lastq.size(), 2);
        if (lastq.size() == 2) chk("b2b_interval", lastq[1] - lastq[0], 4108);
        chk("b2b_nweights", wcyc.size(), 18);
        if (wcyc.size() == 18 && doneq.size() >= 1) chk("b2b_restart", wcyc[9] - doneq[0], 2);
        repeat (3) @(negedge clk);

        // Random contents and random stalls, checked by the model alone.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            pix_en = 1'b1; pix_addr = 14'($urandom_range(0, 4200)); pix_data = 24'($urandom);
            wgt_en = 1'b1; wgt_addr = 4'($urandom_range(0, 15)); wgt_data = 8'($urandom);
            bias_en = ($urandom_range(0, 3) == 0); bias_data = 8'($urandom);
        end
        @(negedge clk);
        pix_en = 1'b0; wgt_en = 1'b0; bias_en = 1'b0;
        clr();
        start_pulse();
        begin
            bit seen = 0;
            for (int i = 0; i < 20000 && !seen; i++) begin
                @(negedge clk);
                if (o_done) seen = 1;
                hold = ($urandom_range(0, 5) == 0);
            end
            hold = 1'b0;
            n_chk++;
            if (!seen) begin
                n_fail++;
                $display("FAIL done_timeout: random-stall frame never finished");
            end
        end
        chk("rnd_nvalid", nvalid, NB);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
